// File: rtl/div_restoring_pkg.sv
// div_pkg: shared constants for the restoring divider.
//   DIV_W   - default operand/quotient/remainder width
//   state_t - 3-bit FSM state encoding used by control_div
package div_pkg;

  localparam int DIV_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t LOAD    = 3'd1;
  localparam state_t SHIFT   = 3'd2;
  localparam state_t TEST    = 3'd3;
  localparam state_t DONE_ST = 3'd4;

endpackage

// File: rtl/div_restoring_if.sv
// div_restoring_if: start/busy/done handshake plus operand and result buses
// between the calculator top (master) and the divider (slave).
//   master drives start, dividend, divisor; slave drives quotient,
//   remainder, busy, done, div_by_zero.
interface div_restoring_if import div_pkg::*; #(
  parameter int W = DIV_W
);

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/control_div.sv
// control_div: sequencing FSM of the restoring divider (no datapath).
//   inputs : clk, reset_n, start, divisor_zero, count_zero
//   outputs: load/shift/test datapath strobes, busy, done (decoded from state)
// Latency: LOAD, then SHIFT/TEST pairs until count_zero, then DONE_ST.
// start is only looked at in IDLE; there is no other backpressure.
module control_div import div_pkg::*; (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic divisor_zero,
  input  logic count_zero,
  output logic load,
  output logic shift,
  output logic test,
  output logic busy,
  output logic done
);

  state_t state, state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = divisor_zero ? DONE_ST : SHIFT;
      SHIFT:   state_nxt = TEST;
      TEST:    state_nxt = count_zero ? DONE_ST : SHIFT;
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    test  = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      LOAD:    begin load  = 1'b1; busy = 1'b1; end
      SHIFT:   begin shift = 1'b1; busy = 1'b1; end
      TEST:    begin test  = 1'b1; busy = 1'b1; end
      DONE_ST: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/div_restoring.sv
// div_restoring: sequential restoring (shift-subtract) divider, one quotient
// bit per SHIFT/TEST pair. Ports: clk, reset_n (async, active low), and
// bus (div_restoring_if.slave: start/dividend/divisor in; quotient/remainder/
// busy/done/div_by_zero out). Latency: done 2W+2 cycles after start is
// sampled, 2 cycles for divide by zero. start is ignored while busy.
// Optional macro SIGNED_DIV_EN: two's complement operands, quotient truncates
// toward zero, remainder takes the dividend's sign.
module div_restoring import div_pkg::*; #(
  parameter int W = DIV_W
) (
  input  logic             clk,
  input  logic             reset_n,
  div_restoring_if.slave   bus
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(W);

  logic [W:0]    r;      // partial remainder, one guard bit for the trial subtract
  logic [W-1:0]  q;
  logic [W-1:0]  d;
  logic [CW-1:0] count;

  logic load, shift, test;
  logic divisor_zero, count_zero;

  logic [W:0]   diff;
  logic [W-1:0] q_new, r_new;
  logic [W-1:0] a_mag, b_mag;

  assign divisor_zero = (bus.divisor == '0);
  assign count_zero   = (count == '0);

  control_div u_ctrl (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (bus.start),
    .divisor_zero (divisor_zero),
    .count_zero   (count_zero),
    .load         (load),
    .shift        (shift),
    .test         (test),
    .busy         (bus.busy),
    .done         (bus.done)
  );

`ifdef SIGNED_DIV_EN
  logic sign_q, sign_r;
  // Magnitudes; -2^(W-1) maps to 2^(W-1), which is still exact unsigned.
  assign a_mag = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
  assign b_mag = bus.divisor[W-1]  ? -bus.divisor  : bus.divisor;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
`endif

  // Trial subtract: a clear MSB means the divisor fits, so keep the difference.
  always_comb begin
    diff  = r - {1'b0, d};
    q_new = {q[W-1:1], ~diff[W]};
    r_new = diff[W] ? r[W-1:0] : diff[W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r               <= '0;
      q               <= '0;
      d               <= '0;
      count           <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
`endif
    end else if (load) begin
      r               <= '0;
      q               <= a_mag;
      d               <= b_mag;
      count           <= COUNT_INIT;
      bus.div_by_zero <= divisor_zero;
      // Divide by zero is fully resolved here; the FSM goes straight to DONE_ST.
      if (divisor_zero) begin
        bus.quotient  <= '1;
        bus.remainder <= bus.dividend;
      end
`ifdef SIGNED_DIV_EN
      sign_q          <= bus.dividend[W-1] ^ bus.divisor[W-1];
      sign_r          <= bus.dividend[W-1];
`endif
    end else if (shift) begin
      r     <= {r[W-1:0], q[W-1]};
      q     <= {q[W-2:0], 1'b0};
      count <= count - CW'(1);
    end else if (test) begin
      r <= {1'b0, r_new};
      q <= q_new;
      if (count_zero) begin
`ifdef SIGNED_DIV_EN
        bus.quotient  <= sign_q ? -q_new : q_new;
        bus.remainder <= sign_r ? -r_new : r_new;
`else
        bus.quotient  <= q_new;
        bus.remainder <= r_new;
`endif
      end
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// Scoreboard bench for div_restoring (W=8): each accepted start pushes the
// expected quotient/remainder/flag, done cycle and busy cycle count; the
// monitor pops and compares on every done pulse.
module tb_div_restoring;
  import div_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           done_cyc;
    int           busy_cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   busy_cnt;
  exp_t sb[$];

  div_restoring_if #(.W(W)) bus();

  div_restoring #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference results straight from the arithmetic definition.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int c0);
    exp_t e;
    int   x, y;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.dz = 1'b1;
      e.done_cyc = c0 + 2;
      e.busy_cyc = 1;
    end else begin
`ifdef SIGNED_DIV_EN
      x = $signed(a) / $signed(b);
      y = $signed(a) % $signed(b);
`else
      x = int'(a) / int'(b);
      y = int'(a) % int'(b);
`endif
      e.q = x[W-1:0];
      e.r = y[W-1:0];
      e.dz = 1'b0;
      e.done_cyc = c0 + 2*W + 2;
      e.busy_cyc = 2*W + 1;
    end
    return e;
  endfunction

  // Monitor: sample half a cycle away from the active edge.
  initial begin
    exp_t e;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt = 0;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
          if (sb.size() == 0) begin
            chk("spurious_done", 32'(bus.done), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("quotient",    32'(bus.quotient),    32'(e.q));
            chk("remainder",   32'(bus.remainder),   32'(e.r));
            chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
            chk("done_cycle",  32'(cyc),             32'(e.done_cyc));
            chk("busy_cycles", 32'(busy_cnt),        32'(e.busy_cyc));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Called #1 after a posedge with the DUT in IDLE; start is sampled at the next edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    sb.push_back(model(a, b, cyc));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    #1;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_quotient"},    32'(bus.quotient),    32'd0);
    chk({tag, "_remainder"},   32'(bus.remainder),   32'd0);
    chk({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
    chk({tag, "_busy"},        32'(bus.busy),        32'd0);
    chk({tag, "_done"},        32'(bus.done),        32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic case, with latency and busy window.
    issue(8'd100, 8'd7);
    wait_idle();

    // Boundary operand patterns.
    issue(8'd255, 8'd1);   wait_idle();
    issue(8'd5,   8'd9);   wait_idle();
    issue(8'd200, 8'd200); wait_idle();

    // Divide by zero, then a normal op must clear the flag.
    issue(8'd42, 8'd0);    wait_idle();
    issue(8'd9,  8'd3);    wait_idle();

    // A second start while busy must be ignored (no extra done, no operand reload).
    issue(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    #1;
    bus.dividend = 8'd50;
    bus.divisor  = 8'd5;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();

    // start held high: second op begins the cycle after DONE_ST.
    bus.dividend = 8'd201;
    bus.divisor  = 8'd13;
    bus.start    = 1'b1;
    sb.push_back(model(8'd201, 8'd13, cyc));
    sb.push_back(model(8'd201, 8'd13, cyc + 2*W + 3));
    repeat (2*W + 4) @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-operation clears outputs at once, no done follows.
    issue(8'd100, 8'd7);
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk_cleared("abort");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue(8'd9, 8'd4);
    wait_idle();

`ifdef SIGNED_DIV_EN
    issue(8'h9C, 8'd7);    wait_idle();   // -100 / 7
    issue(8'd100, 8'hF9);  wait_idle();   // 100 / -7
    issue(8'h80, 8'hFF);   wait_idle();   // -128 / -1 wraps
    issue(8'hD6, 8'd0);    wait_idle();   // -42 / 0
`endif

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
